bcd_converter_seq: RTL and testbench

Sequential, parametrised binary-to-BCD converter using the iterative double-dabble (shift-add-3) algorithm, one bit per clock. It replaces the purely combinational 8-bit/3-digit converter for wide display values, such as rotary counters and frequency readouts, where a combinational cascade would limit fmax. It adds a valid/ready handshake on both sides, signed-input mode, overflow saturation and a leading-zero blanking mask for seven-segment drivers.

---
 rtl/bcd_converter_seq.sv | 166 ++++++++++++++++
 tb/tb_bcd_converter_seq.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_converter_seq.sv
// Sequential binary-to-BCD converter (double dabble, one input bit per clock).
// A word is accepted through a valid/ready handshake. After BIN_WIDTH shift cycles, one
// further cycle registers the result (with saturation and leading-zero mask). The result
// is then held until the consumer takes it.
module bcd_converter_seq #(
  parameter int unsigned BIN_WIDTH = 16,
  parameter int unsigned DIGITS    = 5,
  parameter int unsigned SIGNED    = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_WIDTH-1:0]  bin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  sign,
  output logic                  overflow,
  output logic [DIGITS-1:0]     digit_active
);

  localparam int unsigned AccW = 4 * DIGITS;
  localparam int unsigned CntW = $clog2(BIN_WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e               state_q, state_d;
  logic [BIN_WIDTH-1:0] sr_q, sr_d;
  logic [AccW-1:0]      acc_q, acc_d;
  logic                 trk_q, trk_d;
  logic                 sign_pend_q, sign_pend_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [AccW-1:0]      bcd_q, bcd_d;
  logic                 sign_q, sign_d;
  logic                 ovf_q, ovf_d;
  logic [DIGITS-1:0]    act_q, act_d;

  logic [BIN_WIDTH-1:0] mag;
  logic                 neg;
  logic [AccW-1:0]      acc_adj;
  logic [DIGITS-1:0]    act_calc;
  logic                 any_nz;

  // Magnitude and sign of the incoming word
  always_comb begin
    neg = 1'b0;
    mag = bin;
    if (SIGNED != 0 && bin[BIN_WIDTH-1]) begin
      neg = 1'b1;
      mag = ~bin + BIN_WIDTH'(1);
    end
  end

  // Add-3 correction of every accumulator digit that is 5 or more
  always_comb begin
    acc_adj = acc_q;
    for (int k = 0; k < int'(DIGITS); k++) begin
      if (acc_q[4*k +: 4] >= 4'd5) begin
        acc_adj[4*k +: 4] = acc_q[4*k +: 4] + 4'd3;
      end
    end
  end

  // Leading-zero mask: digit k is lit if it or any higher digit is nonzero
  always_comb begin
    act_calc = '0;
    any_nz   = 1'b0;
    for (int k = int'(DIGITS) - 1; k >= 0; k--) begin
      any_nz      = any_nz | (|acc_q[4*k +: 4]);
      act_calc[k] = any_nz;
    end
    act_calc[0] = 1'b1;
  end

  // Next-state and datapath control
  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    acc_d       = acc_q;
    trk_d       = trk_q;
    sign_pend_d = sign_pend_q;
    cnt_d       = cnt_q;
    bcd_d       = bcd_q;
    sign_d      = sign_q;
    ovf_d       = ovf_q;
    act_d       = act_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          sr_d        = mag;
          sign_pend_d = neg;
          acc_d       = '0;
          trk_d       = 1'b0;
          cnt_d       = '0;
          state_d     = StShift;
        end
      end
      StShift: begin
        if (cnt_q < CntW'(BIN_WIDTH)) begin
          {acc_d, sr_d} = {acc_adj[AccW-2:0], sr_q, 1'b0};
          // A bit leaving the top digit means the value needs more digits
          trk_d         = trk_q | acc_adj[AccW-1];
          cnt_d         = cnt_q + CntW'(1);
        end else begin
          // All bits shifted in; register the final result
          sign_d = sign_pend_q;
          if (trk_q) begin
            bcd_d = {DIGITS{4'h9}};
            ovf_d = 1'b1;
            act_d = '1;
          end else begin
            bcd_d = acc_q;
            ovf_d = 1'b0;
            act_d = act_calc;
          end
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      sr_q        <= '0;
      acc_q       <= '0;
      trk_q       <= 1'b0;
      sign_pend_q <= 1'b0;
      cnt_q       <= '0;
      bcd_q       <= '0;
      sign_q      <= 1'b0;
      ovf_q       <= 1'b0;
      act_q       <= DIGITS'(1);
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      acc_q       <= acc_d;
      trk_q       <= trk_d;
      sign_pend_q <= sign_pend_d;
      cnt_q       <= cnt_d;
      bcd_q       <= bcd_d;
      sign_q      <= sign_d;
      ovf_q       <= ovf_d;
      act_q       <= act_d;
    end
  end

  // Handshake flags decode only the state register
  always_comb begin
    in_ready     = (state_q == StIdle);
    out_valid    = (state_q == StDone);
    bcd          = bcd_q;
    sign         = sign_q;
    overflow     = ovf_q;
    digit_active = act_q;
  end

endmodule

// File: tb/tb_bcd_converter_seq.sv
// Scoreboard bench for bcd_converter_seq: three instances (16/5/0, 16/4/0, 8/3/1).
// Drivers push expected results when a word is issued. Per-instance monitors compare
// every cycle a result is presented and pop the entry on the handshake.
module tb_bcd_converter_seq;

  typedef struct {
    logic [39:0] bcd;
    logic        sign;
    logic        ovf;
    logic [9:0]  act;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  // DUT0: 16/5/0
  logic        rst_n0, in_valid0, in_ready0, out_valid0, out_ready0, sign0, overflow0;
  logic [15:0] bin0;
  logic [19:0] bcd0;
  logic [4:0]  act0;
  // DUT1: 16/4/0
  logic        rst_n1, in_valid1, in_ready1, out_valid1, out_ready1, sign1, overflow1;
  logic [15:0] bin1;
  logic [15:0] bcd1;
  logic [3:0]  act1;
  // DUT2: 8/3/1
  logic        rst_n2, in_valid2, in_ready2, out_valid2, out_ready2, sign2, overflow2;
  logic [7:0]  bin2;
  logic [11:0] bcd2;
  logic [2:0]  act2;

  bcd_converter_seq #(.BIN_WIDTH(16), .DIGITS(5), .SIGNED(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n0), .in_valid(in_valid0), .in_ready(in_ready0), .bin(bin0),
    .out_valid(out_valid0), .out_ready(out_ready0), .bcd(bcd0), .sign(sign0),
    .overflow(overflow0), .digit_active(act0)
  );
  bcd_converter_seq #(.BIN_WIDTH(16), .DIGITS(4), .SIGNED(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n1), .in_valid(in_valid1), .in_ready(in_ready1), .bin(bin1),
    .out_valid(out_valid1), .out_ready(out_ready1), .bcd(bcd1), .sign(sign1),
    .overflow(overflow1), .digit_active(act1)
  );
  bcd_converter_seq #(.BIN_WIDTH(8), .DIGITS(3), .SIGNED(1)) u_dut2 (
    .clk(clk), .rst_n(rst_n2), .in_valid(in_valid2), .in_ready(in_ready2), .bin(bin2),
    .out_valid(out_valid2), .out_ready(out_ready2), .bcd(bcd2), .sign(sign2),
    .overflow(overflow2), .digit_active(act2)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  function automatic exp_t mk(input logic [39:0] b, input logic s, input logic o,
                              input logic [9:0] a);
    exp_t e;
    e.bcd  = b;
    e.sign = s;
    e.ovf  = o;
    e.act  = a;
    return e;
  endfunction

  // Monitors: compare while a result is held, pop on handshake
  always @(negedge clk) begin
    if (rst_n0 && out_valid0) begin
      if (q0.size() == 0) fail_now("dut0 unexpected result");
      else begin
        chk("dut0 bcd", 64'(bcd0), 64'(q0[0].bcd));
        chk("dut0 sign", 64'(sign0), 64'(q0[0].sign));
        chk("dut0 ovf", 64'(overflow0), 64'(q0[0].ovf));
        chk("dut0 act", 64'(act0), 64'(q0[0].act));
        chk("dut0 in_ready while done", 64'(in_ready0), 64'(0));
        if (out_ready0) void'(q0.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n1 && out_valid1) begin
      if (q1.size() == 0) fail_now("dut1 unexpected result");
      else begin
        chk("dut1 bcd", 64'(bcd1), 64'(q1[0].bcd));
        chk("dut1 sign", 64'(sign1), 64'(q1[0].sign));
        chk("dut1 ovf", 64'(overflow1), 64'(q1[0].ovf));
        chk("dut1 act", 64'(act1), 64'(q1[0].act));
        if (out_ready1) void'(q1.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n2 && out_valid2) begin
      if (q2.size() == 0) fail_now("dut2 unexpected result");
      else begin
        chk("dut2 bcd", 64'(bcd2), 64'(q2[0].bcd));
        chk("dut2 sign", 64'(sign2), 64'(q2[0].sign));
        chk("dut2 ovf", 64'(overflow2), 64'(q2[0].ovf));
        chk("dut2 act", 64'(act2), 64'(q2[0].act));
        if (out_ready2) void'(q2.pop_front());
      end
    end
  end

  // Drivers: hold in_valid until accepted, push the expectation when issued
  task automatic send0(input logic [15:0] v, input bit push, input exp_t e);
    int n = 0;
    in_valid0 = 1'b1;
    bin0      = v;
    while (!in_ready0 && n < 200) begin @(posedge clk); #1; n++; end
    if (!in_ready0) fail_now("dut0 accept timeout");
    if (push) q0.push_back(e);
    @(posedge clk); #1;
    in_valid0 = 1'b0;
  endtask

  task automatic send1(input logic [15:0] v, input exp_t e);
    int n = 0;
    in_valid1 = 1'b1;
    bin1      = v;
    while (!in_ready1 && n < 200) begin @(posedge clk); #1; n++; end
    if (!in_ready1) fail_now("dut1 accept timeout");
    q1.push_back(e);
    @(posedge clk); #1;
    in_valid1 = 1'b0;
  endtask

  task automatic send2(input logic [7:0] v, input exp_t e);
    int n = 0;
    in_valid2 = 1'b1;
    bin2      = v;
    while (!in_ready2 && n < 200) begin @(posedge clk); #1; n++; end
    if (!in_ready2) fail_now("dut2 accept timeout");
    q2.push_back(e);
    @(posedge clk); #1;
    in_valid2 = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q0.size() + q1.size() + q2.size()) != 0 && n < 300) begin
      @(posedge clk); #1; n++;
    end
    if ((q0.size() + q1.size() + q2.size()) != 0) fail_now("drain timeout");
  endtask

  task automatic chk_reset0(input string tag);
    chk({tag, " in_ready"}, 64'(in_ready0), 64'(1));
    chk({tag, " out_valid"}, 64'(out_valid0), 64'(0));
    chk({tag, " bcd"}, 64'(bcd0), 64'(0));
    chk({tag, " sign"}, 64'(sign0), 64'(0));
    chk({tag, " ovf"}, 64'(overflow0), 64'(0));
    chk({tag, " act"}, 64'(act0), 64'(5'b00001));
  endtask

  initial begin
    int n;
    exp_t none;
    none = mk(40'h0, 1'b0, 1'b0, 10'h0);
    rst_n0 = 1'b0; rst_n1 = 1'b0; rst_n2 = 1'b0;
    in_valid0 = 1'b0; in_valid1 = 1'b0; in_valid2 = 1'b0;
    bin0 = '0; bin1 = '0; bin2 = '0;
    out_ready0 = 1'b1; out_ready1 = 1'b1; out_ready2 = 1'b1;
    #12;
    chk_reset0("reset");
    @(posedge clk); #1;
    rst_n0 = 1'b1; rst_n1 = 1'b1; rst_n2 = 1'b1;
    @(posedge clk); #1;
    chk_reset0("after reset");
    chk("dut2 reset act", 64'(act2), 64'(3'b001));

    // Zero and full-scale on the default instance, with exact latency
    send0(16'd0, 1'b1, mk(40'h00000, 1'b0, 1'b0, 10'b00001));
    drain();
    send0(16'd65535, 1'b1, mk(40'h65535, 1'b0, 1'b0, 10'b11111));
    n = 0;
    while (!out_valid0 && n < 40) begin @(posedge clk); #1; n++; end
    chk("dut0 latency", 64'(n), 64'(17));
    drain();

    // Backpressure: result held 10 cycles; a second word waits for the handshake
    send0(16'd1234, 1'b1, mk(40'h01234, 1'b0, 1'b0, 10'b01111));
    out_ready0 = 1'b0;
    fork
      send0(16'd7, 1'b1, mk(40'h00007, 1'b0, 1'b0, 10'b00001));
      begin
        n = 0;
        while (!out_valid0 && n < 40) begin @(posedge clk); #1; n++; end
        if (!out_valid0) fail_now("dut0 hold wait timeout");
        repeat (10) begin
          @(posedge clk); #1;
          chk("dut0 hold out_valid", 64'(out_valid0), 64'(1));
        end
        out_ready0 = 1'b1;
        @(posedge clk); #1;
        chk("dut0 ready after handshake", 64'(in_ready0), 64'(1));
      end
    join
    drain();

    // Overflow saturation and an exact 4-digit fit
    send1(16'd12345, mk(40'h9999, 1'b0, 1'b1, 10'b1111));
    send1(16'd9999, mk(40'h9999, 1'b0, 1'b0, 10'b1111));
    // Signed mode
    send2(8'h80, mk(40'h128, 1'b1, 1'b0, 10'b111));
    send2(8'hFF, mk(40'h001, 1'b1, 1'b0, 10'b001));
    send2(8'h7F, mk(40'h127, 1'b0, 1'b0, 10'b111));
    send2(8'h00, mk(40'h000, 1'b0, 1'b0, 10'b001));
    drain();

    // Reset mid-conversion discards the word
    send0(16'd1000, 1'b0, none);
    repeat (5) @(posedge clk);
    #2;
    rst_n0 = 1'b0;
    #1;
    chk_reset0("async reset");
    @(posedge clk); #1;
    rst_n0 = 1'b1;
    repeat (25) begin
      @(posedge clk); #1;
      chk("dut0 no result after reset", 64'(out_valid0), 64'(0));
    end
    send0(16'd42, 1'b1, mk(40'h00042, 1'b0, 1'b0, 10'b00011));
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
